// File: rtl/ram_multibank_clr.sv
// Multi-bank simple dual-port RAM with bypass, 1/2-cycle read latency,
// and a clear sequencer that rewrites every bank between layers.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   rd_req/addr/data     per-bank read port, bank b at slice b
//   rd_valid             per-bank pulse, READ_LATENCY after accept
//   wr_req/addr/data     per-bank write port
//   clear_req            start a clear (sampled only in IDLE)
//   clear_busy           sequencer owns the arrays
//   clear_done           one-cycle pulse at clear completion
module ram_multibank_clr #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int NUM_BANKS = 4,
  parameter int READ_LATENCY = 2,
  parameter string RAM_TYPE = "block",
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic clk,
  input  logic rst,
  input  logic [NUM_BANKS-1:0] rd_req,
  input  logic [NUM_BANKS*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_BANKS*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_BANKS-1:0] rd_valid,
  input  logic [NUM_BANKS-1:0] wr_req,
  input  logic [NUM_BANKS*ADDR_WIDTH-1:0] wr_addr,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0] wr_data,
  input  logic clear_req,
  output logic clear_busy,
  output logic clear_done
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CNT_LAST =
    {1'b0, {ADDR_WIDTH{1'b1}}};
  localparam logic [ADDR_WIDTH:0] CNT_ONE =
    {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_DONE
  } state_t;

  state_t state_q, state_d;
  logic [ADDR_WIDTH:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (clear_req) begin
          state_d = S_CLEAR;
          cnt_d = '0;
        end
      end
      S_CLEAR: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign clear_busy = (state_q == S_CLEAR);
  assign clear_done = (state_q == S_DONE);

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    (* ram_style = RAM_TYPE *)
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] ra;
    logic [ADDR_WIDTH-1:0] wa_ext;
    logic [ADDR_WIDTH-1:0] wa;
    logic [DATA_WIDTH-1:0] wd_ext;
    logic [DATA_WIDTH-1:0] wd;
    logic we;
    logic re;
    logic hit;
    logic [DATA_WIDTH-1:0] d1;
    logic v1;

    assign ra = rd_addr[b*ADDR_WIDTH +: ADDR_WIDTH];
    assign wa_ext = wr_addr[b*ADDR_WIDTH +: ADDR_WIDTH];
    assign wd_ext = wr_data[b*DATA_WIDTH +: DATA_WIDTH];

    // The sequencer takes the write port outright while busy.
    assign we = clear_busy | wr_req[b];
    assign wa = clear_busy ? cnt_q[ADDR_WIDTH-1:0] : wa_ext;
    assign wd = clear_busy ? CLEAR_VALUE : wd_ext;

    assign re = rd_req[b] & ~clear_busy;
    // Write-first: a same-address write wins over the stored word.
    assign hit = wr_req[b] && (wa_ext == ra);

    always_ff @(posedge clk) begin
      if (we) begin
        mem[wa] <= wd;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        d1 <= '0;
        v1 <= 1'b0;
      end else begin
        v1 <= re;
        if (re) begin
          d1 <= hit ? wd_ext : mem[ra];
        end
      end
    end

    if (READ_LATENCY == 1) begin : g_lat1
      assign rd_data[b*DATA_WIDTH +: DATA_WIDTH] = d1;
      assign rd_valid[b] = v1;
    end else begin : g_lat2
      logic [DATA_WIDTH-1:0] d2;
      logic v2;

      always_ff @(posedge clk) begin
        if (rst) begin
          d2 <= '0;
          v2 <= 1'b0;
        end else begin
          v2 <= v1;
          if (v1) begin
            d2 <= d1;
          end
        end
      end

      assign rd_data[b*DATA_WIDTH +: DATA_WIDTH] = d2;
      assign rd_valid[b] = v2;
    end
  end

endmodule

// File: tb/tb_ram_multibank_clr.sv
// Scoreboard bench for ram_multibank_clr: two instances (latency 2 and 1)
// share stimulus; a negedge monitor pops per-bank expectation queues.
module tb_ram_multibank_clr;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int NB = 4;

  typedef struct {
    int cyc;
    logic [DW-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [NB-1:0] rd_req;
  logic [NB*AW-1:0] rd_addr;
  logic [NB-1:0] wr_req;
  logic [NB*AW-1:0] wr_addr;
  logic [NB*DW-1:0] wr_data;
  logic clear_req;

  logic [NB*DW-1:0] rd_data2, rd_data1;
  logic [NB-1:0] rd_valid2, rd_valid1;
  logic busy2, busy1, done2, done1;

  int cyc = 0;
  int nvec = 0;
  int nerr = 0;

  exp_t q2 [NB][$];
  exp_t q1 [NB][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ram_multibank_clr #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_BANKS(NB),
    .READ_LATENCY(2), .RAM_TYPE("block"), .CLEAR_VALUE('0)
  ) dut2 (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_data(rd_data2), .rd_valid(rd_valid2),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .clear_req(clear_req),
    .clear_busy(busy2), .clear_done(done2)
  );

  ram_multibank_clr #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_BANKS(NB),
    .READ_LATENCY(1), .RAM_TYPE("block"), .CLEAR_VALUE('0)
  ) dut1 (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_data(rd_data1), .rd_valid(rd_valid1),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .clear_req(clear_req),
    .clear_busy(busy1), .clear_done(done1)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic mon_one(int l, int b, logic v, logic [DW-1:0] d);
    exp_t e;
    int sz;
    sz = (l == 2) ? q2[b].size() : q1[b].size();
    if (v === 1'b1) begin
      nvec++;
      if (sz == 0) begin
        nerr++;
        $display("FAIL L%0d bank%0d spurious: got valid data %h at %0d expected none",
                 l, b, d, cyc);
      end else begin
        if (l == 2) e = q2[b].pop_front();
        else e = q1[b].pop_front();
        if (e.cyc != cyc || d !== e.data) begin
          nerr++;
          $display("FAIL L%0d bank%0d read: got %h at cyc %0d expected %h at cyc %0d",
                   l, b, d, cyc, e.data, e.cyc);
        end
      end
    end else if (sz != 0) begin
      if (l == 2) e = q2[b][0];
      else e = q1[b][0];
      if (e.cyc <= cyc) begin
        if (l == 2) void'(q2[b].pop_front());
        else void'(q1[b].pop_front());
        nvec++;
        nerr++;
        $display("FAIL L%0d bank%0d missing: got no valid at %0d expected %h",
                 l, b, cyc, e.data);
      end
    end
  endtask

  always @(negedge clk) begin
    for (int b = 0; b < NB; b++) begin
      mon_one(2, b, rd_valid2[b], rd_data2[b*DW +: DW]);
      mon_one(1, b, rd_valid1[b], rd_data1[b*DW +: DW]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    rd_req = '0;
    wr_req = '0;
    clear_req = 1'b0;
  endtask

  task automatic wr(int b, int a, logic [DW-1:0] d);
    wr_req[b] = 1'b1;
    wr_addr[b*AW +: AW] = a[AW-1:0];
    wr_data[b*DW +: DW] = d;
  endtask

  task automatic rd_nx(int b, int a);
    rd_req[b] = 1'b1;
    rd_addr[b*AW +: AW] = a[AW-1:0];
  endtask

  task automatic rd(int b, int a, logic [DW-1:0] d);
    exp_t e;
    rd_nx(b, a);
    e.data = d;
    e.cyc = cyc + 2;
    q2[b].push_back(e);
    e.cyc = cyc + 1;
    q1[b].push_back(e);
  endtask

  task automatic idle(int n);
    repeat (n) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n2;
    int n1;
    bit seen;
    rst = 1'b1;
    rd_req = '0;
    rd_addr = '0;
    wr_req = '0;
    wr_addr = '0;
    wr_data = '0;
    clear_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rd_data2", rd_data2, 0);
    chk("rst_rd_valid2", rd_valid2, 0);
    chk("rst_busy2", busy2, 0);
    chk("rst_done2", done2, 0);
    chk("rst_rd_data1", rd_data1, 0);
    chk("rst_rd_valid1", rd_valid1, 0);
    chk("rst_busy1", busy1, 0);
    chk("rst_done1", done1, 0);

    tick(); wr(1, 5, 16'h1234);
    tick(); rd(1, 5, 16'h1234);
    idle(4);

    for (int i = 0; i < 4; i++) begin
      tick(); wr(0, i, 16'(16'hA0 + i));
    end
    for (int i = 0; i < 4; i++) begin
      tick(); rd(0, i, 16'(16'hA0 + i));
    end
    idle(4);

    tick(); wr(2, 7, 16'h0001);
    tick(); wr(2, 8, 16'h5555);
    tick(); wr(2, 7, 16'hBEEF); rd(2, 7, 16'hBEEF);
    tick(); wr(2, 7, 16'hCAFE); rd(2, 8, 16'h5555);
    tick(); rd(2, 7, 16'hCAFE);
    idle(4);

    tick();
    for (int b = 0; b < NB; b++) wr(b, 3, 16'((b + 1) * 16'h10));
    tick();
    for (int b = 0; b < NB; b++) rd(b, 3, 16'((b + 1) * 16'h10));
    idle(4);

    for (int a = 0; a < 16; a++) begin
      tick();
      for (int b = 0; b < NB; b++) wr(b, a, 16'hFFFF);
    end
    tick(); rd(3, 9, 16'hFFFF);
    idle(4);

    tick(); clear_req = 1'b1; rd(0, 15, 16'hFFFF);
    for (int i = 1; i <= 17; i++) begin
      tick();
      if (i == 3) clear_req = 1'b1;
      if (i == 10) wr(1, 2, 16'h7777);
      if (i == 12) rd_nx(2, 3);
      if (i == 17) clear_req = 1'b1;
      @(negedge clk);
      chk($sformatf("clr_busy2_c%0d", i), busy2, (i <= 16) ? 1 : 0);
      chk($sformatf("clr_done2_c%0d", i), done2, (i == 17) ? 1 : 0);
      chk($sformatf("clr_busy1_c%0d", i), busy1, (i <= 16) ? 1 : 0);
      chk($sformatf("clr_done1_c%0d", i), done1, (i == 17) ? 1 : 0);
    end
    tick();
    @(negedge clk);
    chk("done_req_ignored_busy2", busy2, 0);
    chk("done_req_ignored_done2", done2, 0);
    chk("done_req_ignored_busy1", busy1, 0);

    for (int a = 0; a < 16; a++) begin
      tick();
      for (int b = 0; b < NB; b++) rd(b, a, 16'h0000);
    end
    idle(4);

    tick(); wr(0, 12, 16'h1111);
    tick(); clear_req = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (i == 5) begin
        rst = 1'b1;
        @(negedge clk);
        chk("midclr_busy_before_rst", busy2, 1);
      end
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("midclr_busy2", busy2, 0);
    chk("midclr_done2", done2, 0);
    chk("midclr_valid2", rd_valid2, 0);
    chk("midclr_busy1", busy1, 0);
    chk("midclr_done1", done1, 0);
    chk("midclr_valid1", rd_valid1, 0);
    tick(); rd(0, 12, 16'h1111);
    idle(4);

    tick(); clear_req = 1'b1;
    n2 = 0;
    n1 = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      @(negedge clk);
      if (busy2 === 1'b1) n2++;
      if (busy1 === 1'b1) n1++;
      if (done2 === 1'b1) seen = 1'b1;
    end
    chk("clr2_busy_cycles2", n2, 16);
    chk("clr2_busy_cycles1", n1, 16);
    chk("clr2_done_seen", seen, 1);
    tick();
    rd(0, 12, 16'h0000);
    rd(1, 0, 16'h0000);
    rd(3, 15, 16'h0000);
    idle(5);

    for (int b = 0; b < NB; b++) begin
      chk($sformatf("drain_q2_b%0d", b), q2[b].size(), 0);
      chk($sformatf("drain_q1_b%0d", b), q1[b].size(), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
